// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution datapath: default widths, window FSM
// states and the flat-window bit-offset helper used by producer and consumer.
package cnn_pkg;

    localparam int DEF_BIT_REP_IN  = 8;
    localparam int DEF_KERNEL_SIZE = 3;

    typedef enum logic {
        ST_FILL   = 1'b0,
        ST_STREAM = 1'b1
    } win_state_e;

    // Bit offset of window element (i,j); i is the row from the top, j the column from the left.
    function automatic int win_idx(input int i, input int j, input int k,
                                   input int b = DEF_BIT_REP_IN);
        return (i * k + j) * b;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image-row delay: the output is the pixel written DEPTH accepts earlier.
// Contents are never cleared; the window FSM guarantees stale entries are not used.
module conv_line_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = DEF_BIT_REP_IN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] dout
);

    localparam int PW = cnt_w(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic signed [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]            ptr_q;
    logic [PW-1:0]            ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Read-before-write at the same slot gives exactly one row of delay.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[ptr_q] <= din;
        end
    end

    assign dout = mem_q[ptr_q];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator: line-buffer chain, column shift
// registers, raster counters, FILL/STREAM FSM and a single output register stage.
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int BIT_REP_IN  = DEF_BIT_REP_IN,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           flush,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic signed [BIT_REP_IN-1:0]                   in_pixel,
    output logic                                           win_valid,
    input  logic                                           win_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*BIT_REP_IN-1:0]  win_data,
    output logic [cnt_w(IMG_HEIGHT)-1:0]                   win_row,
    output logic [cnt_w(IMG_WIDTH)-1:0]                    win_col,
    output logic                                           win_last
);

    localparam int K  = KERNEL_SIZE;
    localparam int B  = BIT_REP_IN;
    localparam int W  = IMG_WIDTH;
    localparam int H  = IMG_HEIGHT;
    localparam int RW = cnt_w(H);
    localparam int CW = cnt_w(W);
    localparam int DW = K * K * B;

    localparam logic [RW-1:0] ROW_LAST  = RW'(H - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(W - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam win_state_e    ST_INIT   = (K == 1) ? ST_STREAM : ST_FILL;

    win_state_e            state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    logic                  vld_q, vld_d;
    logic                  last_q, last_d;
    logic [DW-1:0]         data_q, data_d;
    logic [RW-1:0]         wrow_q, wrow_d;
    logic [CW-1:0]         wcol_q, wcol_d;
    logic                  accept;
    logic                  produce;
    logic [DW-1:0]         win_flat;

    // chain[0] is the live pixel, chain[k] the pixel from k rows above.
    logic signed [B-1:0]   chain [K];
    logic signed [B-1:0]   sr_q  [K][K];
    logic signed [B-1:0]   sr_d  [K][K];

    assign in_ready = !vld_q || win_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign chain[0] = in_pixel;

    for (genvar k = 0; k < K - 1; k++) begin : g_lb
        conv_line_buffer #(
            .DEPTH  (W),
            .DATA_W (B)
        ) u_lb (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (accept),
            .din   (chain[k]),
            .dout  (chain[k+1])
        );
    end

    // Shift every window row left by one column, new column enters on the right.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
                sr_d[i][j] = sr_q[i][j+1];
            end
            sr_d[i][K-1] = chain[K-1-i];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sr_q <= sr_d;
        end
    end

    always_comb begin
        win_flat = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                win_flat[win_idx(i, j, K, B) +: B] = sr_d[i][j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        vld_d   = vld_q;
        last_d  = last_q;
        data_d  = data_q;
        wrow_d  = wrow_q;
        wcol_d  = wcol_q;
        produce = 1'b0;
        if (flush) begin
            state_d = ST_INIT;
            row_d   = '0;
            col_d   = '0;
            vld_d   = 1'b0;
            last_d  = 1'b0;
        end else begin
            if (vld_q && win_ready) begin
                vld_d  = 1'b0;
                last_d = 1'b0;
            end
            if (accept) begin
                produce = (state_q == ST_STREAM) && (int'(col_q) >= K - 1);
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        state_d = ST_INIT;
                    end else begin
                        row_d = row_q + 1'b1;
                        if (row_q + 1'b1 == ROW_FIRST) begin
                            state_d = ST_STREAM;
                        end
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
                // A new window overrides the consume above, keeping win_valid high.
                if (produce) begin
                    vld_d  = 1'b1;
                    last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
                    data_d = win_flat;
                    wrow_d = row_q - ROW_FIRST;
                    wcol_d = col_q - COL_FIRST;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            row_q   <= '0;
            col_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            wrow_q  <= '0;
            wcol_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            data_q  <= data_d;
            wrow_q  <= wrow_d;
            wcol_q  <= wcol_d;
        end
    end

    assign win_valid = vld_q;
    assign win_last  = last_q;
    assign win_data  = data_q;
    assign win_row   = wrow_q;
    assign win_col   = wcol_q;

endmodule
